fir_out_stage: RTL and testbench

FIR_OUT_STAGE -- requirements
Module: fir_out_stage

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_out_fifo.sv | 48 ++++
 rtl/fir_out_stage.sv | 150 +++++++++++++++
 tb/tb_fir_out_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR output stage: FP29i input fields and FP16 packing constants.
package fir_pkg;

  localparam int FP29_W       = 29;
  localparam int FP29_SIGN    = 28;
  localparam int FP29_EXP_MSB = 27;
  localparam int FP29_EXP_LSB = 22;
  localparam int FP29_EXP_W   = 6;
  localparam int FP29_MAN_W   = 22;
  localparam int FP29_MAN_ONE = 20;
  localparam int BIAS29_DEF   = 31;

  localparam int FP16_BIAS    = 15;
  localparam int FP16_EXP_W   = 5;
  localparam int FP16_FRAC_W  = 10;
  localparam logic [15:0] FP16_MAX_FIN = 16'h7BFF;

  typedef struct packed {
    logic                  sign;
    logic [FP29_EXP_W-1:0] exp;
    logic [FP29_MAN_W-1:0] man;
  } fp29i_t;

  // Position of the highest set bit; 0 for an all-zero magnitude.
  function automatic logic [4:0] lead_one(input logic [FP29_MAN_W-1:0] m);
    logic [4:0] p;
    p = 5'd0;
    for (int i = 0; i < FP29_MAN_W; i++)
      if (m[i]) p = 5'(i);
    return p;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Output FIFO for the FIR stage: power-of-two depth, wrapping pointers, zero on dout while empty.
module fir_out_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk_fast,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk_fast) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fir_out_stage.sv
// FP29i accumulator result to FP16 converter with a credit-controlled output FIFO.
// Optional FIR_OUT_STATS_EN adds saturating overflow/underflow counters.
module fir_out_stage
  import fir_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int BIAS29 = BIAS29_DEF
) (
  input  logic              clk_fast,
  input  logic              rst_n,
  input  logic              res_valid,
  input  logic [FP29_W-1:0] res_fp29i,
  output logic              in_ready,
  output logic [15:0]       dout,
  output logic              valid,
  input  logic              ready,
  output logic              drop_err
`ifdef FIR_OUT_STATS_EN
  ,
  output logic [7:0]        ovf_cnt,
  output logic [7:0]        unf_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          accept;
  logic          pop;

  // S1
  logic          s1_vld;
  fp29i_t        s1_word;
  logic [4:0]    s1_p;

  // S2
  logic [FP29_MAN_W-1:0] aligned;
  logic [9:0]            frac_c;
  logic                  guard_c;
  logic                  sticky_c;
  logic [10:0]           frac_r;
  logic signed [11:0]    e16_c;
  logic                  s2_vld;
  logic                  s2_sign;
  logic                  s2_zero;
  logic [9:0]            s2_frac;
  logic signed [11:0]    s2_exp;

  // S3
  logic                  s2_ovf;
  logic                  s2_unf;
  logic [15:0]           pack_c;
  logic                  s3_vld;
  logic [15:0]           s3_word;

  // Credits cover everything in the pipe so S3 can never hit a full FIFO.
  assign in_ready = !fifo_full &&
                    ((int'(fifo_count) + int'(s1_vld) + int'(s2_vld) + int'(s3_vld)) < DEPTH);
  assign accept   = res_valid && in_ready;
  assign valid    = !fifo_empty;
  assign pop      = valid && ready;

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) drop_err <= 1'b0;
    else if (res_valid && !in_ready) drop_err <= 1'b1;
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) s1_vld <= 1'b0;
    else        s1_vld <= accept;
  end

  always_ff @(posedge clk_fast) begin
    if (accept) begin
      s1_word <= res_fp29i;
      s1_p    <= lead_one(res_fp29i[FP29_MAN_W-1:0]);
    end
  end

  always_comb begin
    aligned  = s1_word.man << (5'd21 - s1_p);
    frac_c   = aligned[20:11];
    guard_c  = aligned[10];
    sticky_c = |aligned[9:0];
    frac_r   = {1'b0, frac_c} + 11'(guard_c && (sticky_c || frac_c[0]));
    e16_c    = 12'(int'(s1_word.exp) - BIAS29 + int'(s1_p) - FP29_MAN_ONE + FP16_BIAS);
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) s2_vld <= 1'b0;
    else        s2_vld <= s1_vld;
  end

  // A rounding carry bumps the exponent and leaves the fraction at zero.
  always_ff @(posedge clk_fast) begin
    if (s1_vld) begin
      s2_sign <= s1_word.sign;
      s2_zero <= ~aligned[21];
      s2_frac <= frac_r[9:0];
      s2_exp  <= e16_c + 12'(frac_r[10]);
    end
  end

  always_comb begin
    s2_ovf = !s2_zero && (s2_exp >= 12'sd31);
    s2_unf = !s2_zero && (s2_exp <= 12'sd0);
    pack_c = {s2_sign, s2_exp[4:0], s2_frac};
    if (s2_zero || s2_unf) pack_c = {s2_sign, 15'b0};
    else if (s2_ovf)       pack_c = {s2_sign, FP16_MAX_FIN[14:0]};
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) s3_vld <= 1'b0;
    else        s3_vld <= s2_vld;
  end

  always_ff @(posedge clk_fast) begin
    if (s2_vld) s3_word <= pack_c;
  end

`ifdef FIR_OUT_STATS_EN
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= 8'd0;
      unf_cnt <= 8'd0;
    end else if (s2_vld) begin
      if (s2_ovf && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
      if (s2_unf && unf_cnt != 8'hFF) unf_cnt <= unf_cnt + 8'd1;
    end
  end
`endif

  fir_out_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk_fast (clk_fast),
    .rst_n    (rst_n),
    .push     (s3_vld),
    .din      (s3_word),
    .pop      (pop),
    .dout     (dout),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_fir_out_stage.sv
// Self-checking bench for fir_out_stage: directed cases plus a randomized streaming run against an arithmetic model.
module tb_fir_out_stage;

  localparam int DEPTH = 4;
  localparam int BIAS  = 31;

  logic        clk_fast = 1'b0;
  logic        rst_n    = 1'b0;
  logic        res_valid = 1'b0;
  logic [28:0] res_fp29i = '0;
  logic        in_ready;
  logic [15:0] dout;
  logic        valid;
  logic        ready = 1'b0;
  logic        drop_err;
`ifdef FIR_OUT_STATS_EN
  logic [7:0]  ovf_cnt;
  logic [7:0]  unf_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int ovf_exp  = 0;
  int unf_exp  = 0;
  logic [15:0] exp_q[$];

  fir_out_stage #(.DEPTH(DEPTH), .BIAS29(BIAS)) dut (
    .clk_fast  (clk_fast),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_fp29i (res_fp29i),
    .in_ready  (in_ready),
    .dout      (dout),
    .valid     (valid),
    .ready     (ready),
    .drop_err  (drop_err)
`ifdef FIR_OUT_STATS_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
`endif
  );

  always #5 clk_fast = ~clk_fast;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
  endtask

  function automatic logic [28:0] mk(input bit s, input int e, input int m);
    return {s, 6'(e), 22'(m)};
  endfunction

  // Value-level reference: find the leading one, round the 11-bit significand
  // to nearest-even by integer remainder, then apply saturation and flush.
  function automatic void ref_conv(input logic [28:0] w, output logic [15:0] r,
                                   output bit ov, output bit un);
    bit s;
    int e, m, p, sh, q, rem, half, ex;
    s  = w[28];
    e  = int'(w[27:22]);
    m  = int'(w[21:0]);
    ov = 1'b0;
    un = 1'b0;
    if (m == 0) begin
      r = {s, 15'b0};
      return;
    end
    p = 0;
    for (int i = 0; i < 22; i++) if (((m >> i) & 1) == 1) p = i;
    sh = p - 10;
    if (sh <= 0) q = m << (-sh);
    else begin
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
    end
    ex = e - BIAS + p - 20 + 15;
    if (q == 2048) begin
      q  = 1024;
      ex = ex + 1;
    end
    if (ex >= 31) begin
      ov = 1'b1;
      r  = {s, 15'h7BFF};
    end else if (ex <= 0) begin
      un = 1'b1;
      r  = {s, 15'b0};
    end else r = {s, 5'(ex), 10'(q)};
  endfunction

  function automatic logic [28:0] rand_word();
    int pb, m;
    pb = $urandom_range(0, 22);
    if (pb == 22) m = 0;
    else m = (1 << pb) | (int'($urandom) & ((1 << pb) - 1));
    return mk(1'($urandom_range(0, 1)), $urandom_range(0, 63), m);
  endfunction

  task automatic send(input logic [28:0] w);
    res_fp29i = w;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [28:0] w, input logic [15:0] expv);
    send(w);
    tick();
    tick();
    check({tag, "_early_valid"}, 32'(valid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(expv));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_popped"}, 32'(valid), 32'd0);
  endtask

  // Compare the FIFO head against the scoreboard whenever a pop happens this cycle.
  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (valid && ready) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check(tag, 32'(dout), 32'(e));
    end
  endtask

  initial begin
    logic [15:0] r;
    bit ov, un;
    logic [15:0] burst [4];
    int outs;

    // Reset state
    tick();
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed conversions
    run_one("one", mk(0, 31, 'h100000), 16'h3C00);
    run_one("tie_even", mk(0, 31, 'h100200), 16'h3C00);
    run_one("round_up", mk(0, 31, 'h100600), 16'h3C02);
    run_one("carry", mk(0, 31, 'h1FFE00), 16'h4000);
    run_one("sat", mk(0, 63, 'h100000), 16'h7BFF);
    ovf_exp++;
`ifdef FIR_OUT_STATS_EN
    check("ovf_cnt_1", 32'(ovf_cnt), 32'(ovf_exp));
`endif
    run_one("flush", mk(1, 0, 'h000001), 16'h8000);
    unf_exp++;
    run_one("neg_zero", mk(1, 20, 0), 16'h8000);
`ifdef FIR_OUT_STATS_EN
    check("unf_cnt_1", 32'(unf_cnt), 32'(unf_exp));
`endif

    // Back-pressure: four results fill the credits, the fifth is dropped
    burst[0] = 16'h3C00; burst[1] = 16'h3C02; burst[2] = 16'h4000; burst[3] = 16'hBC00;
    send(mk(0, 31, 'h100000));
    send(mk(0, 31, 'h100600));
    send(mk(0, 32, 'h100000));
    check("credit_3_ready", 32'(in_ready), 32'd1);
    send(mk(1, 31, 'h100000));
    check("credit_full", 32'(in_ready), 32'd0);
    check("no_drop_yet", 32'(drop_err), 32'd0);
    send(mk(0, 40, 'h100000));
    check("drop_err_set", 32'(drop_err), 32'd1);
    tick(); tick(); tick();
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 32'(valid), 32'd1);
      check("drain_order", 32'(dout), 32'(burst[i]));
      tick();
    end
    check("drain_empty", 32'(valid), 32'd0);
    ready = 1'b0;

    // Randomized streaming with random back-pressure
    for (int cyc = 0; cyc < 400; cyc++) begin
      ready     = ($urandom_range(0, 3) != 0);
      res_valid = ($urandom_range(0, 2) != 0);
      res_fp29i = rand_word();
      pop_check("stream_dout");
      if (res_valid && in_ready) begin
        ref_conv(res_fp29i, r, ov, un);
        exp_q.push_back(r);
        if (ov && ovf_exp < 255) ovf_exp++;
        if (un && unf_exp < 255) unf_exp++;
      end
      tick();
    end
    res_valid = 1'b0;
    ready     = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      pop_check("flush_dout");
      tick();
    end
    check("stream_left", 32'(exp_q.size()), 32'd0);
    check("stream_valid_end", 32'(valid), 32'd0);
`ifdef FIR_OUT_STATS_EN
    check("ovf_cnt_rand", 32'(ovf_cnt), 32'(ovf_exp));
    check("unf_cnt_rand", 32'(unf_cnt), 32'(unf_exp));
`endif

    // Reset with two buffered and one in flight
    ready = 1'b0;
    send(mk(0, 31, 'h100000));
    send(mk(0, 31, 'h100000));
    tick(); tick(); tick();
    send(mk(0, 31, 'h100000));
    check("pre_rst_valid", 32'(valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(valid), 32'd0);
    check("midrst_drop_err", 32'(drop_err), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_dout", 32'(dout), 32'h0);
`ifdef FIR_OUT_STATS_EN
    check("midrst_ovf_cnt", 32'(ovf_cnt), 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    tick();
    send(mk(0, 31, 'h100000));
    ready = 1'b1;
    outs  = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (valid) begin
        outs++;
        check("post_rst_dout", 32'(dout), 32'h3C00);
      end
      tick();
    end
    check("post_rst_count", 32'(outs), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
